// File: rtl/switch_allocator_if.sv
// Shared packet type and allocator port bundle. `N (inputs) and `M (outputs) default to 5
// when not supplied on the command line.
`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif

package switch_allocator_pkg;
    localparam int N = `N;
    localparam int M = `M;

    typedef struct packed {
        logic        ant;
        logic [30:0] payload;
    } packet_t;
endpackage

interface switch_allocator_if #(
    parameter int CREDIT_DEPTH = 4
);
    import switch_allocator_pkg::*;
    localparam int CW = $clog2(CREDIT_DEPTH + 1);

    packet_t [0:N-1]         i_data;
    logic    [0:N-1]         i_data_val;
    logic    [0:N-1][0:M-1]  i_output_req;
    logic    [0:M-1]         i_credit;
    packet_t [0:M-1]         o_data;
    logic    [0:M-1]         o_data_val;
    logic    [0:N-1]         o_en;
    logic    [0:M-1][CW-1:0] o_credit_cnt;

    modport master (
        output i_data, i_data_val, i_output_req, i_credit,
        input  o_data, o_data_val, o_en, o_credit_cnt
    );

    modport slave (
        input  i_data, i_data_val, i_output_req, i_credit,
        output o_data, o_data_val, o_en, o_credit_cnt
    );
endinterface

// File: rtl/switch_allocator.sv
// Router switch allocator: per-output round-robin arbitration with credit flow control.
// Define ANT_PRIORITY_EN to let ant packets win over normal packets on each output.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int CREDIT_DEPTH = 4,
    parameter int X_LOC        = 0,
    parameter int Y_LOC        = 0
) (
    input logic              clk,
    input logic              reset,
    switch_allocator_if.slave bus
);
    localparam int CW = $clog2(CREDIT_DEPTH + 1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic    [0:N-1][0:M-1]  eff_req;
    logic    [0:M-1]         grant;
    logic    [0:M-1][PW-1:0] win;
    logic    [0:N-1]         en;

    packet_t [0:M-1]         data_q;
    logic    [0:M-1]         val_q;
    logic    [0:M-1][CW-1:0] cnt_q, cnt_d;
    logic    [0:M-1][PW-1:0] rr_q, rr_d;

    // A directional request overrides local; among directions the lowest index wins.
    always_comb begin
        logic dir_found;
        eff_req   = '0;
        dir_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            dir_found = 1'b0;
            if (bus.i_data_val[i]) begin
                for (int m = 1; m < M; m++) begin
                    if (!dir_found && bus.i_output_req[i][m]) begin
                        eff_req[i][m] = 1'b1;
                        dir_found     = 1'b1;
                    end
                end
                if (!dir_found && bus.i_output_req[i][0]) begin
                    eff_req[i][0] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [0:N-1] cand;
        logic [0:N-1] ants;
        int           idx;
        grant = '0;
        win   = '0;
        cand  = '0;
        ants  = '0;
        idx   = 0;
        for (int m = 0; m < M; m++) begin
            for (int i = 0; i < N; i++) begin
                cand[i] = eff_req[i][m];
                ants[i] = eff_req[i][m] & bus.i_data[i].ant;
            end
`ifdef ANT_PRIORITY_EN
            if (|ants) begin
                cand = ants;
            end
`endif
            if (cnt_q[m] != '0) begin
                for (int k = 0; k < N; k++) begin
                    idx = int'(rr_q[m]) + k;
                    if (idx >= N) begin
                        idx = idx - N;
                    end
                    if (!grant[m] && cand[idx]) begin
                        grant[m] = 1'b1;
                        win[m]   = PW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        en = '0;
        if (!reset) begin
            for (int m = 0; m < M; m++) begin
                if (grant[m]) begin
                    en[win[m]] = 1'b1;
                end
            end
        end
    end

    // Credit count saturates at full; the pointer moves just past the winner.
    always_comb begin
        int t;
        t = 0;
        for (int m = 0; m < M; m++) begin
            t = int'(cnt_q[m]) + int'(bus.i_credit[m]) - int'(grant[m]);
            if (t > CREDIT_DEPTH) begin
                t = CREDIT_DEPTH;
            end
            cnt_d[m] = CW'(t);
            rr_d[m]  = rr_q[m];
            if (grant[m]) begin
                rr_d[m] = (int'(win[m]) == N - 1) ? '0 : win[m] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            val_q  <= '0;
            rr_q   <= '0;
            for (int m = 0; m < M; m++) begin
                cnt_q[m] <= CW'(CREDIT_DEPTH);
            end
        end else begin
            val_q <= grant;
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
            for (int m = 0; m < M; m++) begin
                if (grant[m]) begin
                    data_q[m] <= bus.i_data[win[m]];
                end
            end
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_data_val   = val_q;
    assign bus.o_en         = en;
    assign bus.o_credit_cnt = cnt_q;

    for (genvar m = 0; m < M; m++) begin : g_credit_chk
        a_no_overflow : assert property (@(posedge clk) disable iff (reset)
            !(bus.i_credit[m] && cnt_q[m] == CW'(CREDIT_DEPTH) && !grant[m]))
            else $error("credit overflow at router (%0d,%0d) output %0d", X_LOC, Y_LOC, m);
    end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Output-side allocation and crossbar stage of the router, directly downstream of the per-input routing/ACO agent. Each cycle it takes the per-input packet, valid and one-hot output request vectors produced by the agent. It arbitrates every output port among competing inputs using round-robin and tracks downstream buffer space with per-output credit counters. It registers the winning packets onto the output links and pops the winning inputs from their input queues.

## Interface
Parameters:
- CREDIT_DEPTH, default 4, downstream input-queue depth; initial and maximum credit count per output.
- X_LOC, default 0, router X coordinate; carried for debug and assertions only.
- Y_LOC, default 0, router Y coordinate; carried for debug and assertions only.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_data  input  packet_t[0:`N-1]  packets from the agent.
- i_data_val  input  [0:`N-1]  packet valid per input.
- i_output_req  input  [0:`N-1][0:`M-1]  request per input. Bit order: 0 = local, 1 = +Y, 2 = +X, 3 = −Y, 4 = −X.
- i_credit  input  [0:`M-1]  one-cycle pulse: downstream freed one slot on that output.
- o_data  output  packet_t[0:`M-1]  registered output packets.
- o_data_val  output  [0:`M-1]  registered output valid.
- o_en  output  [0:`N-1]  combinational pop to input queue i, asserted in the grant cycle.
- o_credit_cnt  output  [0:`M-1][$clog2(CREDIT_DEPTH+1)-1:0]  current credits; test visibility.

## Operation
Request normalisation:
- An input is active only when i_data_val[i] is 1 and its request is nonzero.
- If any of bits 1–4 are set, bit 0 is cleared.
- If more than one of bits 1–4 remain, only the lowest-index one is kept.
- The resulting one-hot vector is the effective request.

Arbitration, per output m:
- Candidates are inputs whose effective request selects m.
- The output is eligible only when credit_cnt[m] > 0.
- A round-robin pointer rr[m] in 0..`N-1 sets the order: the first candidate at or after rr[m], wrapping modulo `N, wins.
- Each input wins at most one output per cycle. Because requests are one-hot after normalisation, this holds inherently.

On a grant to input i for output m:
- o_en[i] = 1 in the same cycle.
- o_data[m] <= i_data[i] and o_data_val[m] <= 1 at the next edge.
- rr[m] <= (i+1) mod `N.
- credit_cnt[m] decrements.

Without a grant:
- o_data_val[m] <= 0.
- o_data[m] holds its previous value.
- rr[m] is unchanged.

Credits:
- Next value is credit_cnt + i_credit[m] − grant[m].
- A simultaneous credit return and grant leaves the count unchanged.
- The count saturates at CREDIT_DEPTH; an extra i_credit at maximum is ignored and flagged by a simulation assertion.
- At 0, no grant is issued to that output.

Local output (m = 0) is also credit-controlled; the NIC returns credits on it the same way.

## Timing
- Reset state:
  - o_data = '0, o_data_val = '0.
  - credit_cnt = CREDIT_DEPTH for every output.
  - rr = 0 for every output.
  - o_en is 0 whenever reset is high.
- Latency: a request valid in cycle t appears on o_data/o_data_val in cycle t+1; o_en is driven in cycle t.
- Reset mid-operation: in-flight registered outputs are dropped, credits are restored to full, and pointers go to 0 at that edge.
- Throughput: one packet per output per cycle while credits remain.
- A denied input keeps o_en = 0. Upstream must hold i_data and i_output_req stable until popped.

## Configuration
- ANT_PRIORITY_EN defined: for each output, candidates with i_data.ant = 1 are arbitrated first, using round-robin among ants only. Normal packets compete only when no ant requests that output. The pointer updates to the winner + 1 in both cases.
- ANT_PRIORITY_EN undefined: ant flag is ignored; pure round-robin across all candidates.

## Test plan
- Single packet, input 1 requesting 5'b00100, credits full → cycle 0: o_en = 5'b01000. Cycle 1: o_data_val[2] = 1, o_data[2] equals the input packet, credit_cnt[2] = 3.
- Inputs 0, 2 and 4 all request output 1 for 3 cycles, rr[1] = 0 → grants go to 0, then 2, then 4. o_en toggles accordingly and credit_cnt[1] reaches 1.
- Output 3 sent 4 packets with no i_credit → credit_cnt[3] = 0 and the 5th request is denied. An i_credit[3] pulse gives a grant the next cycle. A grant and credit in the same cycle keeps the count at 1.
- Request 5'b10100 on input 3 → treated as output 2 only; o_data_val[0] stays 0.
- With ANT_PRIORITY_EN defined: normal packet on input 0 and ant on input 4 both request output 4, rr = 0 → input 4 is granted first; the normal packet follows the next cycle. Without the macro, input 0 wins first.
- Assert reset while 3 outputs are valid and credits are partly used → next cycle: all o_data_val = 0, all credit_cnt = 4, o_en = 0.
